// File: rtl/debug_unit_if.sv
// debug_unit_if: UART byte handshake, pipeline debug words and pipeline control between a host side and debug_unit.
// master drives commands, tx_done and the debug words; slave (debug_unit) drives tx bytes and pipeline control.
interface debug_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_done;
    logic [DATA_WIDTH-1:0] pc_addr_in;
    logic [DATA_WIDTH-1:0] pc_instr_in;
    logic [DATA_WIDTH-1:0] reg_w_data_in;
    logic [DATA_WIDTH-1:0] reg_rt_data_in;
    logic [DATA_WIDTH-1:0] reg_rs_data_in;
    logic                  pc_enable;
    logic                  pc_reset;
    logic                  busy;

    modport master (
        output rx_data, rx_valid, tx_done,
        output pc_addr_in, pc_instr_in, reg_w_data_in, reg_rt_data_in, reg_rs_data_in,
        input  tx_data, tx_start, pc_enable, pc_reset, busy
    );

    modport slave (
        input  rx_data, rx_valid, tx_done,
        input  pc_addr_in, pc_instr_in, reg_w_data_in, reg_rt_data_in, reg_rs_data_in,
        output tx_data, tx_start, pc_enable, pc_reset, busy
    );
endinterface

// File: rtl/debug_unit.sv
// debug_unit: UART command FSM (R/C/H/S/D) that resets, runs, halts, steps and dumps pipeline words; DEBUG_CYCLE_COUNT_EN appends a cycle-count word.
// Capture one cycle after 'D' (two after 'S'), first byte the cycle after capture; each byte waits for tx_done, so the transmitter sets the pace.
module debug_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 5
) (
    input logic         clk,
    input logic         reset_n,
    debug_unit_if.slave dbg
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RUN     = 3'd1;
    localparam logic [2:0] STEP    = 3'd2;
    localparam logic [2:0] SNAP    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_D = 8'h44;

`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int TOTAL_WORDS = NUM_WORDS + 1;
`else
    localparam int TOTAL_WORDS = NUM_WORDS;
`endif
    localparam int              NUM_BYTES = 4 * TOTAL_WORDS;
    localparam int              CNT_W     = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam int              BUF_W     = TOTAL_WORDS * DATA_WIDTH;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BUF_W-1:0] snap_q, snap_d;
    logic [BUF_W-1:0] cap_words;
    logic             pc_reset_q, pc_reset_d;
    logic             pc_en;

    assign pc_en = (state_q == RUN) || (state_q == STEP);

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [DATA_WIDTH-1:0] cyc_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_q <= '0;
        end else if (pc_reset_d) begin
            cyc_cnt_q <= '0;
        end else if (pc_en) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
        end
    end

    assign cap_words = {cyc_cnt_q, dbg.reg_rs_data_in, dbg.reg_rt_data_in,
                        dbg.reg_w_data_in, dbg.pc_instr_in, dbg.pc_addr_in};
`else
    assign cap_words = {dbg.reg_rs_data_in, dbg.reg_rt_data_in,
                        dbg.reg_w_data_in, dbg.pc_instr_in, dbg.pc_addr_in};
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        snap_d     = snap_q;
        pc_reset_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg.rx_valid) begin
                    case (dbg.rx_data)
                        CMD_R:   pc_reset_d = 1'b1;
                        CMD_C:   state_d    = RUN;
                        CMD_S:   state_d    = STEP;
                        CMD_D:   state_d    = SNAP;
                        default: state_d    = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (dbg.rx_valid && (dbg.rx_data == CMD_H)) begin
                    state_d = SNAP;
                end
            end
            STEP: state_d = SNAP;
            SNAP: begin
                snap_d     = cap_words;
                byte_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: begin
                // Commands arriving here are dropped; only tx_done advances the dump.
                if (dbg.tx_done) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            snap_q     <= '0;
            pc_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            snap_q     <= snap_d;
            pc_reset_q <= pc_reset_d;
        end
    end

    // Byte k of the dump is bits [8k+7:8k]: little-endian within a word, word 0 lowest.
    assign dbg.tx_data   = snap_q[{byte_cnt_q, 3'b000} +: 8];
    assign dbg.tx_start  = (state_q == SEND);
    assign dbg.pc_enable = pc_en;
    assign dbg.pc_reset  = pc_reset_q;
    assign dbg.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: scoreboard bench for debug_unit with a simple PC pipeline model and a tx_done-driving transmitter.
module tb_debug_unit;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int  NB     = 24;
    localparam bit  CNT_EN = 1'b1;
`else
    localparam int  NB     = 20;
    localparam bit  CNT_EN = 1'b0;
`endif
    localparam logic [31:0] INSTR = 32'h8C22_0004;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    debug_unit_if #(.DATA_WIDTH(32)) dbg ();

    debug_unit #(.DATA_WIDTH(32), .NUM_WORDS(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dbg     (dbg)
    );

    logic [31:0] pipe_pc;
    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)           pipe_pc <= '0;
        else if (dbg.pc_reset)  pipe_pc <= '0;
        else if (dbg.pc_enable) pipe_pc <= pipe_pc + 32'd4;
        else if (pc_load)       pipe_pc <= pc_load_val;
    end
    assign dbg.pc_addr_in = pipe_pc;

    int n_start = 0;
    int n_en = 0;
    int n_overlap = 0;
    always @(negedge clk) begin
        if (dbg.tx_start)                  n_start++;
        if (dbg.pc_enable)                 n_en++;
        if (dbg.pc_enable && dbg.pc_reset) n_overlap++;
    end

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] a, input logic [31:0] rt_w, input logic [31:0] rt,
                             input logic [31:0] rs, input logic [31:0] cnt);
        push_word(a);
        push_word(INSTR);
        push_word(rt_w);
        push_word(rt);
        push_word(rs);
        if (CNT_EN) push_word(cnt);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        dbg.rx_valid = 1'b1;
        dbg.rx_data  = c;
        @(negedge clk);
        dbg.rx_valid = 1'b0;
    endtask

    // Acts as the UART transmitter; optionally injects 'D' together with tx_done, or stops at a byte.
    task automatic do_dump(input int n, input int inject_at, input int abort_at);
        int t;
        logic [7:0] held;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!dbg.tx_start && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (!dbg.tx_start) begin
                chk("tx_start_timeout", 32'd0, 32'd1);
                return;
            end
            if (i == abort_at) return;
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
                e = 8'h00;
            end else begin
                e = exp_q.pop_front();
            end
            chk($sformatf("byte%0d", i), {24'd0, dbg.tx_data}, {24'd0, e});
            held = dbg.tx_data;
            repeat (2) @(negedge clk);
            chk($sformatf("hold%0d", i), {24'd0, dbg.tx_data}, {24'd0, held});
            dbg.tx_done = 1'b1;
            if (i == inject_at) begin
                dbg.rx_valid = 1'b1;
                dbg.rx_data  = 8'h44;
            end
            @(negedge clk);
            dbg.tx_done  = 1'b0;
            dbg.rx_valid = 1'b0;
        end
    endtask

    initial begin
        int s0;
        int e0;
        dbg.rx_valid       = 1'b0;
        dbg.rx_data        = 8'h00;
        dbg.tx_done        = 1'b0;
        dbg.pc_instr_in    = INSTR;
        dbg.reg_w_data_in  = '0;
        dbg.reg_rt_data_in = '0;
        dbg.reg_rs_data_in = '0;

        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'd0, dbg.tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, dbg.tx_data}, 32'd0);
        chk("rst_pc_enable", {31'd0, dbg.pc_enable}, 32'd0);
        chk("rst_pc_reset", {31'd0, dbg.pc_reset}, 32'd0);
        chk("rst_busy", {31'd0, dbg.busy}, 32'd0);
        reset_n = 1'b1;

        // 'D' with pc=0x10: latency and little-endian byte order.
        pc_load_val = 32'h10;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        s0 = n_start;
        push_dump(32'h10, 32'd0, 32'd0, 32'd0, 32'd0);
        send_cmd(8'h44);
        chk("d_n1_tx_start", {31'd0, dbg.tx_start}, 32'd0);
        chk("d_n1_busy", {31'd0, dbg.busy}, 32'd1);
        @(negedge clk);
        chk("d_n2_tx_start", {31'd0, dbg.tx_start}, 32'd1);
        do_dump(NB, -1, -1);
        chk("d_busy_end", {31'd0, dbg.busy}, 32'd0);
        chk("d_nstart", n_start - s0, NB);

        // 'H' in IDLE is ignored.
        s0 = n_start;
        e0 = n_en;
        send_cmd(8'h48);
        repeat (4) @(negedge clk);
        chk("h_idle_busy", {31'd0, dbg.busy}, 32'd0);
        chk("h_idle_nstart", n_start - s0, 32'd0);
        chk("h_idle_nen", n_en - e0, 32'd0);

        // 'R' pulses pc_reset once and clears the cycle count.
        send_cmd(8'h52);
        chk("r_pc_reset", {31'd0, dbg.pc_reset}, 32'd1);
        chk("r_busy", {31'd0, dbg.busy}, 32'd0);
        @(negedge clk);
        chk("r_pc_reset_drop", {31'd0, dbg.pc_reset}, 32'd0);
        chk("r_nstart", n_start - s0, 32'd0);
        push_dump(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        send_cmd(8'h44);
        do_dump(NB, -1, -1);

        // 'S' steps one cycle; 'D' injected mid-dump alongside tx_done.
        dbg.reg_w_data_in  = 32'hA1B2_C3D4;
        dbg.reg_rt_data_in = 32'h1122_3344;
        dbg.reg_rs_data_in = 32'hDEAD_BEEF;
        s0 = n_start;
        e0 = n_en;
        push_dump(32'd4, 32'hA1B2_C3D4, 32'h1122_3344, 32'hDEAD_BEEF, 32'd1);
        send_cmd(8'h53);
        chk("s_n1_pc_enable", {31'd0, dbg.pc_enable}, 32'd1);
        @(negedge clk);
        chk("s_n2_pc_enable", {31'd0, dbg.pc_enable}, 32'd0);
        do_dump(NB, 9, -1);
        chk("s_nen", n_en - e0, 32'd1);
        chk("s_nstart", n_start - s0, NB);
        chk("s_busy_end", {31'd0, dbg.busy}, 32'd0);

        // 'C' then 'H' 100 cycles later; 'D' injected on the final tx_done.
        send_cmd(8'h52);
        @(negedge clk);
        s0 = n_start;
        e0 = n_en;
        push_dump(32'h190, 32'hA1B2_C3D4, 32'h1122_3344, 32'hDEAD_BEEF, 32'h64);
        send_cmd(8'h43);
        repeat (98) @(negedge clk);
        send_cmd(8'h48);
        chk("ch_halted", {31'd0, dbg.pc_enable}, 32'd0);
        do_dump(NB, NB - 1, -1);
        chk("ch_nen", n_en - e0, 32'd100);
        chk("ch_nstart", n_start - s0, NB);
        repeat (3) @(negedge clk);
        chk("ch_busy_end", {31'd0, dbg.busy}, 32'd0);

        // Reset with byte 7 on the line aborts the dump.
        push_dump(32'h190, 32'hA1B2_C3D4, 32'h1122_3344, 32'hDEAD_BEEF, 32'h64);
        send_cmd(8'h44);
        do_dump(NB, -1, 7);
        reset_n = 1'b0;
        #1;
        chk("abort_tx_start", {31'd0, dbg.tx_start}, 32'd0);
        chk("abort_tx_data", {24'd0, dbg.tx_data}, 32'd0);
        chk("abort_busy", {31'd0, dbg.busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = n_start;
        repeat (30) @(negedge clk);
        chk("abort_quiet", n_start - s0, 32'd0);
        push_dump(32'd0, 32'hA1B2_C3D4, 32'h1122_3344, 32'hDEAD_BEEF, 32'd0);
        send_cmd(8'h44);
        do_dump(NB, -1, -1);
        chk("post_nstart", n_start - s0, NB);

        chk("sb_drained", exp_q.size(), 32'd0);
        chk("en_rst_overlap", n_overlap, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each debug word; it is fixed at 32.
REQ-002 The block SHALL have parameter NUM_WORDS, default 5, giving the number of pipeline debug words per snapshot.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  command byte from the UART receiver.
REQ-006 rx_valid  in  1  one-cycle pulse qualifying rx_data.
REQ-007 tx_data  out  8  byte presented to the UART transmitter.
REQ-008 tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
REQ-009 tx_done  in  1  one-cycle pulse from the transmitter when the byte is finished.
REQ-010 pc_addr_in, pc_instr_in, reg_w_data_in, reg_rt_data_in, reg_rs_data_in  in  32 each  pipeline debug words.
REQ-011 pc_enable  out  1  pipeline PC/stage enable.
REQ-012 pc_reset  out  1  pipeline reset, active-high.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, STEP, SNAP, SEND and WAIT_TX.
REQ-015 Commands SHALL be accepted only in IDLE, except 'H' (0x48), which is also accepted in RUN; any other byte, or a byte arriving in any other state, SHALL be ignored.
REQ-016 'R' (0x52) in IDLE SHALL drive pc_reset high for exactly one cycle and return to IDLE without transmitting.
REQ-017 'C' (0x43) in IDLE SHALL enter RUN, where pc_enable is held high every cycle.
REQ-018 'H' in RUN SHALL drop pc_enable on the next cycle and enter SNAP.
REQ-019 'S' (0x53) in IDLE SHALL enter STEP, which drives pc_enable high for exactly one cycle, then SNAP.
REQ-020 'D' (0x44) in IDLE SHALL enter SNAP directly.
REQ-021 SNAP SHALL last one cycle and latch all debug words into a snapshot buffer, in the order pc_addr, pc_instr, reg_w_data, reg_rt_data, reg_rs_data.
REQ-022 SEND SHALL present the next byte on tx_data with tx_start high for one cycle, then go to WAIT_TX.
REQ-023 Bytes SHALL be sent little-endian within each word, words in buffer order.
REQ-024 A byte counter SHALL run 0..(4*words - 1).
REQ-025 WAIT_TX SHALL hold tx_data stable until tx_done, then go to SEND, or to IDLE after the last byte.
REQ-026 Latency: with 'D' accepted at cycle N, the capture SHALL occur at N+1 and the first tx_start at N+2.
REQ-027 Latency: with 'S' accepted at cycle N, pc_enable SHALL be high at N+1 only and the capture SHALL occur at N+2.
REQ-028 tx_done arriving outside WAIT_TX SHALL be ignored.
REQ-029 rx_valid and tx_done in the same cycle SHALL be processed independently; the byte is dropped unless the FSM is in IDLE or RUN.
REQ-030 pc_enable and pc_reset SHALL never be high in the same cycle.

Reset
REQ-031 While reset_n is low: state = IDLE, tx_start = 0, tx_data = 0x00, pc_enable = 0, pc_reset = 0, busy = 0, byte counter = 0, snapshot buffer = 0.
REQ-032 A reset in the middle of a transfer SHALL abort it; no tx_start SHALL be issued until a new command is received after reset release.

Configuration
REQ-033 Macro DEBUG_CYCLE_COUNT_EN SHALL control an optional cycle counter.
REQ-034 When DEBUG_CYCLE_COUNT_EN is defined, a 32-bit counter SHALL increment on every cycle with pc_enable high and wrap from 0xFFFFFFFF to 0.
REQ-035 When DEBUG_CYCLE_COUNT_EN is defined, the counter SHALL be cleared by reset_n and by the 'R' command.
REQ-036 When DEBUG_CYCLE_COUNT_EN is defined, the counter SHALL be latched in SNAP as a sixth word, giving a 24-byte dump.
REQ-037 When DEBUG_CYCLE_COUNT_EN is undefined, the counter SHALL be absent and every dump SHALL be 20 bytes.

Verification
REQ-038 pc_addr=0x00000010, pc_instr=0x8C220004, other words 0, 'D' -> tx bytes 10 00 00 00 04 00 22 8C then 12 bytes 00, one tx_start per tx_done, busy=0 after the last tx_done.
REQ-039 'S' with the pipeline at pc_addr=0x0 -> pc_enable high exactly one cycle; the dump reports pc_addr=0x00000004.
REQ-040 'C', then 'H' 100 cycles later -> pc_enable high 100 consecutive cycles, then a dump; with DEBUG_CYCLE_COUNT_EN, the last word is 0x00000064 (24 bytes).
REQ-041 'D' sent while busy, and 'H' sent in IDLE -> no effect; byte count and state sequence unchanged.
REQ-042 reset_n low after byte 7 of a dump -> outputs go to reset values immediately; no further tx_start until a new 'D'.
REQ-043 'R' in IDLE -> pc_reset high exactly one cycle, pc_enable 0, no tx_start; with DEBUG_CYCLE_COUNT_EN, the next dump reports a count of 0.
